// File: rtl/rec_cef_rot_ctrl.sv
// rec_cef_rot_ctrl: sequencer stepping the rec / idle / ec three-slot coefficient buffer pipeline
module rec_cef_rot_ctrl #(
    parameter int LCU_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 sys_start_i,
    input  logic [LCU_CNT_W-1:0] sys_lcu_num_i,
    input  logic                 rec_done_i,
    input  logic                 ec_done_i,
    output logic                 rotate_o,
    output logic                 rec_start_o,
    output logic                 ec_start_o,
    output logic [LCU_CNT_W-1:0] rec_lcu_idx_o,
    output logic [LCU_CNT_W-1:0] ec_lcu_idx_o,
    output logic                 busy_o,
    output logic                 frame_done_o
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ROT   = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    logic [2:0]           state;
    logic [LCU_CNT_W-1:0] total, issue_cnt, rec_idx, mid_idx, ec_idx;
    logic                 rec_v, mid_v, ec_v, rec_flag, ec_flag, rec_ok, ec_ok;
    // a stage is satisfied when idle, already done, or finishing this cycle
    always_comb begin
        rec_ok = !rec_v || rec_flag || rec_done_i;
        ec_ok  = !ec_v || ec_flag || ec_done_i;
    end
    assign rotate_o      = state == ROT;
    assign rec_start_o   = state == START && rec_v;
    assign ec_start_o    = state == START && ec_v;
    assign busy_o        = state != IDLE;
    assign frame_done_o  = state == DONE;
    assign rec_lcu_idx_o = rec_idx;
    assign ec_lcu_idx_o  = ec_idx;
    // frame sequencing: rotate slots, start stages, wait for dones, flush at end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            total     <= '0;
            issue_cnt <= '0;
            rec_idx   <= '0;
            mid_idx   <= '0;
            ec_idx    <= '0;
            rec_v     <= 1'b0;
            mid_v     <= 1'b0;
            ec_v      <= 1'b0;
            rec_flag  <= 1'b0;
            ec_flag   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (sys_start_i && sys_lcu_num_i != '0) begin
                    total     <= sys_lcu_num_i;
                    issue_cnt <= '0;
                    state     <= ROT;
                end
                ROT: begin
                    ec_v     <= mid_v;
                    mid_v    <= rec_v;
                    rec_v    <= issue_cnt < total;
                    ec_idx   <= mid_idx;
                    mid_idx  <= rec_idx;
                    rec_idx  <= issue_cnt;
                    rec_flag <= 1'b0;
                    ec_flag  <= 1'b0;
                    state    <= START;
                end
                START: begin
                    if (rec_v) issue_cnt <= issue_cnt + LCU_CNT_W'(1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (rec_done_i && rec_v) rec_flag <= 1'b1;
                    if (ec_done_i && ec_v) ec_flag <= 1'b1;
                    if (rec_ok && ec_ok)
                        state <= (issue_cnt == total && !rec_v && !mid_v) ? DONE : ROT;
                end
                DONE: begin
                    rec_v <= 1'b0;
                    mid_v <= 1'b0;
                    ec_v  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/rec_cef_rot_ctrl.md
Name: rec_cef_rot_ctrl

Overview:
Sequencer for the three-buffer rotating coefficient store (rec_buf_cef_rot). It steps a 3-slot LCU pipeline: rec writes one slot, one slot idles, and ec reads the third. It issues the buffer rotate pulse and the per-stage start pulses, collects per-stage done pulses, and flushes the pipeline at frame end. An LCU written by rec is read by ec two rotations later.

Parameters:
LCU_CNT_W, 16, width of LCU count and index fields

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
sys_start_i  in  1  frame start pulse; accepted only in IDLE
sys_lcu_num_i  in  LCU_CNT_W  LCUs in frame; sampled with sys_start_i
rec_done_i  in  1  rec stage finished current LCU (pulse)
ec_done_i  in  1  ec stage finished current LCU (pulse)
rotate_o  out  1  one-cycle pulse to rec_buf_cef_rot rotate_i
rec_start_o  out  1  one-cycle pulse: rec may begin LCU rec_lcu_idx_o
ec_start_o  out  1  one-cycle pulse: ec may begin LCU ec_lcu_idx_o
rec_lcu_idx_o  out  LCU_CNT_W  LCU index held in rec slot
ec_lcu_idx_o  out  LCU_CNT_W  LCU index held in ec slot
busy_o  out  1  high in any state except IDLE
frame_done_o  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset: all outputs 0. FSM = IDLE. Slot valids rec_v/mid_v/ec_v = 0. issue_cnt = 0. Done flags = 0. Reset mid-frame aborts immediately with no flush. The external rotate counter is not touched.
- States: IDLE, ROT, START, WAIT, DONE.
- IDLE: sys_start_i=1 and sys_lcu_num_i!=0 -> latch total and clear issue_cnt, then go to ROT. If sys_lcu_num_i==0, stay in IDLE with no pulses. sys_start_i outside IDLE is ignored.
- ROT (1 cycle):
  - rotate_o=1.
  - Shift slots: ec_v<=mid_v, mid_v<=rec_v, rec_v<=(issue_cnt<total).
  - Indices shift the same way: ec_idx<=mid_idx, mid_idx<=rec_idx, rec_idx<=issue_cnt.
  - Clear both done flags. Go to START.
- START (1 cycle):
  - rec_start_o=rec_v, ec_start_o=ec_v.
  - If rec_v, issue_cnt+=1.
  - Go to WAIT.
- WAIT:
  - rec_done_i sets rec_flag only if rec_v. ec_done_i sets ec_flag only if ec_v.
  - Done pulses for an inactive stage, and repeat pulses, are ignored.
  - Simultaneous rec and ec done are both captured.
  - Completion condition: (!rec_v|rec_flag)&(!ec_v|ec_flag). The mid slot needs no done.
  - On completion: if issue_cnt==total and !rec_v and !mid_v, go to DONE; otherwise go to ROT.
  - With no active stage, WAIT lasts exactly 1 cycle.
- DONE (1 cycle): frame_done_o=1, clear valids, go to IDLE.
- Counts:
  - A frame of N LCUs produces exactly N+2 rotate_o pulses.
  - N rec_start_o pulses, with indices 0..N-1 in order.
  - N ec_start_o pulses, with the same indices, each issued 2 rotations after the matching rec start.
- Minimum gap between rotate_o pulses is 3 cycles (ROT, START, WAIT).
- Done pulses arriving in ROT, START, IDLE or DONE are ignored. Engines guarantee done is at least 1 cycle after their start pulse.
- Index outputs are held between updates and are only meaningful while the matching valid is set.
- issue_cnt never exceeds total; no wrap-around.

Test Plan:
- Reset, then sys_start_i with N=1, rec_done 2 cycles after rec_start, ec_done 2 cycles after ec_start -> 3 rotate_o pulses, rec_start(idx 0), ec_start(idx 0) after the 3rd rotate, frame_done_o once, busy_o falls with it.
- N=4 with dones returned 1 cycle after each start -> 6 rotate_o pulses. rec idx 0,1,2,3 and ec idx 0,1,2,3. ec_start for idx k coincides with rec_start for idx k+2 (k=0,1).
- Overlap window: ec_done arrives 10 cycles before rec_done -> no rotate until rec_done. Next rotate_o is exactly 1 cycle after rec_done is sampled (ROT follows WAIT).
- rec_done_i and ec_done_i pulsed in the same cycle -> both captured; next cycle is ROT.
- Stray pulses: ec_done_i pulsed during the first two stages (ec_v=0), and a double rec_done -> ignored; rotate count unchanged.
- Control corner cases:
  - sys_start_i with N=0 -> busy_o stays 0, no pulses.
  - sys_start_i again mid-frame -> ignored.
  - rstn asserted mid-frame -> all outputs 0 immediately.
  - A new start after reset runs normally.
